// File: rtl/snow64_bfloat16_div_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one BFloat16 divider.
// One operation is in flight at a time: grant, ISSUE, WAIT (bounded by a timeout), RESP.
module snow64_bfloat16_div_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  div_start,
  output logic [15:0]           div_a,
  output logic [15:0]           div_b,
  input  logic                  div_data_valid,
  input  logic                  div_can_accept_cmd,
  input  logic [15:0]           div_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_lastGrant;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_grant;
  logic             w_done;
  logic             w_timeout;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [15:0]      r_respData;
  logic             r_respErr;

  // Round-robin search starting just above the most recently served requester.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(r_lastGrant) + 1 + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_grant   = (r_state == IDLE) && w_found && div_can_accept_cmd && !rst;
  assign w_done    = div_data_valid && div_can_accept_cmd;
  assign w_timeout = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    div_start   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          req_ready   = NUM_REQ'(1) << w_winner;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        div_start   = !rst;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (w_done || w_timeout) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        // Suppressed while reset is asserted so a discarded operation never responds.
        if (!rst) begin
          resp_valid = NUM_REQ'(1) << r_owner;
        end
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= IDX_W'(NUM_REQ - 1);
      r_owner     <= '0;
      r_count     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_respData  <= '0;
      r_respErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_a     <= req_a[int'(w_winner)*16 +: 16];
            r_b     <= req_b[int'(w_winner)*16 +: 16];
          end
        end
        ISSUE: r_count <= '0;
        WAIT: begin
          r_count <= r_count + CNT_W'(1);
          // A real result wins over a timeout that expires in the same cycle.
          if (w_done) begin
            r_respData <= div_data;
            r_respErr  <= 1'b0;
          end else if (w_timeout) begin
            r_respData <= 16'h0000;
            r_respErr  <= 1'b1;
          end
        end
        RESP: r_lastGrant <= r_owner;
        default: ;
      endcase
    end
  end

  assign div_a     = r_a;
  assign div_b     = r_b;
  assign resp_data = r_respData;
  assign resp_err  = r_respErr;

endmodule

// File: tb/tb_snow64_bfloat16_div_arbiter.sv
// Directed bench for the divider arbiter: the bench plays the requesters and the divider stub.
module tb_snow64_bfloat16_div_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        div_start;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic        div_data_valid;
  logic        div_can_accept_cmd;
  logic [15:0] div_data;

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  snow64_bfloat16_div_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_data_valid(div_data_valid), .div_can_accept_cmd(div_can_accept_cmd),
    .div_data(div_data)
  );

  // Outputs are driven and sampled 1ns after the falling edge, away from the rising edge.
  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; div_can_accept_cmd = 1'b1;
    div_data_valid = 1'b0; div_data = 16'h0;
    req_a = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    req_b = {16'h5555, 16'h6666, 16'h7777, 16'h8888};
    repeat (2) @(negedge clk);
    #1;
    nVec++; if (req_ready !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_req_ready got %b want 0000", req_ready); end
    nVec++; if (resp_valid !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_resp_valid got %b want 0000", resp_valid); end
    nVec++; if (resp_data !== 16'h0) begin nFail++; $display("[TB] FAIL reset_resp_data got %h want 0000", resp_data); end
    nVec++; if (resp_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_resp_err got %b want 0", resp_err); end
    nVec++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    nVec++; if (div_start !== 1'b0) begin nFail++; $display("[TB] FAIL reset_div_start got %b want 0", div_start); end
    nVec++; if (div_a !== 16'h0 || div_b !== 16'h0) begin nFail++; $display("[TB] FAIL reset_div_ops got %h/%h want 0000/0000", div_a, div_b); end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0000;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0010;
    req_a = {16'h0, 16'h0, 16'h4040, 16'h0};
    req_b = {16'h0, 16'h0, 16'h4000, 16'h0};
    #1;
    nVec++; if (req_ready !== 4'b0010) begin nFail++; $display("[TB] FAIL single_ready got %b want 0010", req_ready); end
    nVec++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL single_busy_idle got %b want 0", busy); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    nVec++; if (div_start !== 1'b1) begin nFail++; $display("[TB] FAIL single_start got %b want 1", div_start); end
    nVec++; if (div_a !== 16'h4040 || div_b !== 16'h4000) begin nFail++; $display("[TB] FAIL single_ops got %h/%h want 4040/4000", div_a, div_b); end
    nVec++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin nFail++; $display("[TB] FAIL single_issue got ready=%b busy=%b want 0000/1", req_ready, busy); end
    @(negedge clk);
    div_data_valid = 1'b1; div_data = 16'h3FC0;
    #1;
    nVec++; if (div_start !== 1'b0 || resp_valid !== 4'b0000) begin nFail++; $display("[TB] FAIL single_wait got start=%b resp=%b want 0/0000", div_start, resp_valid); end
    @(negedge clk);
    div_data_valid = 1'b0;
    #1;
    nVec++; if (resp_valid !== 4'b0010) begin nFail++; $display("[TB] FAIL single_resp_valid got %b want 0010", resp_valid); end
    nVec++; if (resp_data !== 16'h3FC0 || resp_err !== 1'b0) begin nFail++; $display("[TB] FAIL single_resp_data got %h err=%b want 3fc0 err=0", resp_data, resp_err); end
    @(negedge clk);
    #1;
    nVec++; if (resp_valid !== 4'b0000 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL single_after got resp=%b busy=%b want 0000/0", resp_valid, busy); end
    nVec++; if (resp_data !== 16'h3FC0 || div_a !== 16'h4040) begin nFail++; $display("[TB] FAIL single_hold got data=%h a=%h want 3fc0/4040", resp_data, div_a); end
  endtask

  task automatic test_round_robin();
    logic [3:0] expGrant;
    int cnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req_valid = 4'b1111;
    req_a = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    req_b = {16'h0203, 16'h0202, 16'h0201, 16'h0200};
    #1;
    for (int g = 0; g < 5; g++) begin
      expGrant = 4'b0001 << (g % 4);
      cnt = 0;
      while (req_ready === 4'b0000 && cnt < 8) begin
        @(negedge clk); #1; cnt++;
      end
      nVec++; if (req_ready !== expGrant) begin nFail++; $display("[TB] FAIL rr_grant%0d got %b want %b", g, req_ready, expGrant); end
      @(negedge clk); #1;
      nVec++; if (div_start !== 1'b1 || div_a !== 16'(16'h0100 + g % 4)) begin nFail++; $display("[TB] FAIL rr_issue%0d got start=%b a=%h want 1/%h", g, div_start, div_a, 16'(16'h0100 + g % 4)); end
      @(negedge clk);
      div_data_valid = 1'b1; div_data = 16'(16'h1000 + g);
      #1;
      nVec++; if (div_start !== 1'b0) begin nFail++; $display("[TB] FAIL rr_wait_start%0d got %b want 0", g, div_start); end
      @(negedge clk);
      div_data_valid = 1'b0;
      #1;
      nVec++; if (resp_valid !== expGrant || resp_data !== 16'(16'h1000 + g) || div_start !== 1'b0) begin
        nFail++; $display("[TB] FAIL rr_resp%0d got v=%b d=%h s=%b want %b/%h/0", g, resp_valid, resp_data, div_start, expGrant, 16'(16'h1000 + g));
      end
      @(negedge clk); #1;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_stall();
    int bad = 0;
    @(negedge clk);
    div_can_accept_cmd = 1'b0; req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 8; i++) begin
      nVec++; if (req_ready !== 4'b0000 || busy !== 1'b0 || div_start !== 1'b0) begin
        nFail++; bad++; $display("[TB] FAIL stall_cycle%0d got ready=%b busy=%b start=%b want 0000/0/0", i, req_ready, busy, div_start);
      end
      @(negedge clk); #1;
    end
    req_valid = 4'b0000; div_can_accept_cmd = 1'b1;
  endtask

  task automatic test_timeout();
    int early = 0;
    @(negedge clk);
    req_valid = 4'b0100;
    req_a = {16'h0, 16'h1234, 16'h0, 16'h0};
    req_b = {16'h0, 16'h5678, 16'h0, 16'h0};
    #1;
    nVec++; if (req_ready !== 4'b0100) begin nFail++; $display("[TB] FAIL timeout_grant got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    nVec++; if (div_start !== 1'b1 || div_a !== 16'h1234 || div_b !== 16'h5678) begin nFail++; $display("[TB] FAIL timeout_issue got s=%b a=%h b=%h want 1/1234/5678", div_start, div_a, div_b); end
    repeat (64) begin
      @(negedge clk); #1;
      if (resp_valid !== 4'b0000 || busy !== 1'b1) early++;
    end
    nVec++; if (early != 0) begin nFail++; $display("[TB] FAIL timeout_early got %0d bad wait cycles want 0", early); end
    @(negedge clk); #1;
    nVec++; if (resp_valid !== 4'b0100 || resp_err !== 1'b1 || resp_data !== 16'h0000) begin
      nFail++; $display("[TB] FAIL timeout_resp got v=%b err=%b d=%h want 0100/1/0000", resp_valid, resp_err, resp_data);
    end
    @(negedge clk); #1;
    nVec++; if (resp_valid !== 4'b0000 || resp_err !== 1'b1) begin nFail++; $display("[TB] FAIL timeout_hold got v=%b err=%b want 0000/1", resp_valid, resp_err); end
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    @(negedge clk);
    req_valid = 4'b1000;
    req_a = {16'h3F80, 16'h0, 16'h0, 16'h4000};
    req_b = {16'h3F80, 16'h0, 16'h0, 16'h3F80};
    #1;
    nVec++; if (req_ready !== 4'b1000) begin nFail++; $display("[TB] FAIL rstwait_grant got %b want 1000", req_ready); end
    @(negedge clk); req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; div_data_valid = 1'b1; div_data = 16'h7777;
    #1;
    nVec++; if (busy !== 1'b0 || resp_valid !== 4'b0000 || div_start !== 1'b0 || req_ready !== 4'b0000) begin
      nFail++; $display("[TB] FAIL rstwait_ctrl got busy=%b v=%b s=%b r=%b want 0/0000/0/0000", busy, resp_valid, div_start, req_ready);
    end
    nVec++; if (resp_data !== 16'h0 || resp_err !== 1'b0 || div_a !== 16'h0 || div_b !== 16'h0) begin
      nFail++; $display("[TB] FAIL rstwait_data got d=%h err=%b a=%h b=%h want 0000/0/0000/0000", resp_data, resp_err, div_a, div_b);
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (resp_valid !== 4'b0000 || busy !== 1'b0) bad++;
    end
    nVec++; if (bad != 0) begin nFail++; $display("[TB] FAIL rstwait_late_valid got %0d bad cycles want 0", bad); end
    @(negedge clk);
    div_data_valid = 1'b0; req_valid = 4'b1001;
    #1;
    nVec++; if (req_ready !== 4'b0001) begin nFail++; $display("[TB] FAIL rstwait_priority got %b want 0001", req_ready); end
    @(negedge clk); req_valid = 4'b0000;
    @(negedge clk); div_data_valid = 1'b1; div_data = 16'h5555;
    @(negedge clk); div_data_valid = 1'b0;
    #1;
    nVec++; if (resp_valid !== 4'b0001 || resp_data !== 16'h5555) begin nFail++; $display("[TB] FAIL rstwait_resp got v=%b d=%h want 0001/5555", resp_valid, resp_data); end
  endtask

  task automatic test_drop();
    int bad = 0;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    nVec++; if (req_ready !== 4'b0001) begin nFail++; $display("[TB] FAIL drop_grant got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    if (req_ready[2] !== 1'b0 || resp_valid[2] !== 1'b0) bad++;
    @(negedge clk);
    req_valid = 4'b0000; div_data_valid = 1'b1; div_data = 16'h2222;
    #1;
    if (req_ready[2] !== 1'b0 || resp_valid[2] !== 1'b0) bad++;
    @(negedge clk);
    div_data_valid = 1'b0;
    #1;
    nVec++; if (resp_valid !== 4'b0001 || resp_data !== 16'h2222) begin nFail++; $display("[TB] FAIL drop_resp got v=%b d=%h want 0001/2222", resp_valid, resp_data); end
    repeat (4) begin
      @(negedge clk); #1;
      if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || busy !== 1'b0) bad++;
    end
    nVec++; if (bad != 0) begin nFail++; $display("[TB] FAIL drop_ignored got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_timeout();
    test_reset_in_wait();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/snow64_bfloat16_div_arbiter.md
SNOW64_BFLOAT16_DIV_ARBITER -- requirements
Module: snow64_bfloat16_div_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one BFloat16 divider.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum number of WAIT cycles before a forced error response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester request.
REQ-006 SHALL have port req_a, input, 16*NUM_REQ bits: per-requester dividend; slice i is bits [16i+15:16i].
REQ-007 SHALL have port req_b, input, 16*NUM_REQ bits: per-requester divisor, sliced as req_a.
REQ-008 SHALL have port req_ready, output, NUM_REQ bits: one-hot accept pulse.
REQ-009 SHALL have port resp_valid, output, NUM_REQ bits: one-hot result pulse.
REQ-010 SHALL have port resp_data, output, 16 bits: BFloat16 quotient.
REQ-011 SHALL have port resp_err, output, 1 bit: timeout flag, valid with resp_valid.
REQ-012 SHALL have port busy, output, 1 bit: arbiter is not IDLE.
REQ-013 SHALL have port div_start, output, 1 bit: divider start.
REQ-014 SHALL have ports div_a and div_b, outputs, 16 bits each: divider operands.
REQ-015 SHALL have ports div_data_valid and div_can_accept_cmd, inputs, 1 bit each: divider status.
REQ-016 SHALL have port div_data, input, 16 bits: divider result.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-018 In IDLE with any req_valid bit set and div_can_accept_cmd=1, SHALL select a winner round-robin, searching upward from last_grant+1 modulo NUM_REQ.
REQ-019 In the cycle a winner is selected, SHALL drive req_ready[winner]=1 combinationally for that cycle only.
REQ-020 In that same cycle, SHALL register req_a, req_b and owner from the winner, then go to ISSUE.
REQ-021 In IDLE with div_can_accept_cmd=0 or no request, SHALL remain in IDLE and drive req_ready=0.
REQ-022 In ISSUE, SHALL drive div_start=1 for exactly one cycle with the captured operands on div_a/div_b, clear the timeout counter, then go to WAIT.
REQ-023 div_a and div_b SHALL hold the captured operands from ISSUE until the next capture.
REQ-024 In WAIT, when div_data_valid=1 and div_can_accept_cmd=1, SHALL register div_data into resp_data, set resp_err=0, then go to RESP.
REQ-025 In WAIT, the timeout counter SHALL increment every cycle.
REQ-026 If the timeout counter reaches TIMEOUT_CYCLES-1 without completion, SHALL register resp_data=0 and resp_err=1, then go to RESP.
REQ-027 In RESP, SHALL pulse resp_valid[owner]=1 for exactly one cycle, set last_grant<=owner, then go to IDLE.
REQ-028 resp_data and resp_err SHALL hold their values until the next RESP.
REQ-029 Latency SHALL be: grant cycle, ISSUE, WAIT cycles, RESP; at most one operation is in flight, and no new grant is issued before the RESP cycle completes.
REQ-030 Requesters SHALL hold req_valid and their operands stable until req_ready; a request dropped before its grant SHALL be ignored with no response.
REQ-031 A requester that reasserts req_valid in the RESP cycle SHALL be eligible in the following IDLE cycle, subject to round-robin order.
REQ-032 busy SHALL equal (state != IDLE).
REQ-033 div_data_valid SHALL be ignored outside WAIT.

Reset
REQ-034 On rst=1 at a clock edge, SHALL set state=IDLE and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-035 On reset, the following outputs SHALL be 0: req_ready, resp_valid, resp_data, resp_err, busy, div_start, div_a, div_b.
REQ-036 Reset during ISSUE, WAIT or RESP SHALL discard the in-flight operation with no response pulse.
REQ-037 After reset, SHALL not issue until div_can_accept_cmd=1, since the divider has no reset.

Verification
REQ-038 Single request: req_valid=4'b0010, a=0x4040, b=0x4000 -> req_ready=4'b0010 for one cycle; div_start next cycle with div_a=0x4040, div_b=0x4000; then resp_valid=4'b0010, resp_data=0x3FC0, resp_err=0.
REQ-039 All four requesters held valid -> grants in order 0,1,2,3,0; never two div_start pulses without an intervening RESP.
REQ-040 div_can_accept_cmd held 0 with req_valid=4'b1111 -> req_ready=0, busy=0, div_start=0 indefinitely.
REQ-041 Divider stub never asserts div_data_valid -> 64 cycles after entering WAIT, resp_valid[owner]=1, resp_err=1, resp_data=0x0000.
REQ-042 rst asserted during WAIT, then a late div_data_valid -> all outputs 0, no resp_valid pulse; next grant goes to requester 0 when it requests.
REQ-043 Requester 2 drops req_valid while requester 0 is being serviced -> requester 2 receives no req_ready and no resp_valid.
